// File: rtl/reset_seq.sv
// Reset sequencer: synchronises PLL lock, waits for a stable lock window, then
// releases CHANNELS active-high resets in staggered order; aborts on lock loss or sw request.
module reset_seq #(
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                locked_async,
  input  logic                sw_reset_req,
  input  logic                lock_lost_clr,
  output logic [CHANNELS-1:0] resets,
  output logic                ready,
  output logic                lock_lost,
  output logic [7:0]          loss_count
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int unsigned IDX_W  = $clog2(CHANNELS + 1);
  localparam logic [CHANNELS-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;
  logic [LOCK_W-1:0]      lock_cnt;
  logic [STAG_W-1:0]      stag_cnt;
  logic [IDX_W-1:0]       idx;

  // Lock synchroniser; bit 0 is the metastability-catching flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
    end
  end

  assign locked_sync = sync_q[SYNC_STAGES-1];

  // Sequencer FSM; resets shift left so lower channels always release first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HOLD;
      lock_cnt   <= '0;
      stag_cnt   <= '0;
      idx        <= '0;
      resets     <= ALL_ONES;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      if (lock_lost_clr) begin
        lock_lost <= 1'b0;
      end
      case (state)
        HOLD: begin
          resets <= ALL_ONES;
          ready  <= 1'b0;
          if (locked_sync && !sw_reset_req) begin
            if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
              lock_cnt <= '0;
              stag_cnt <= '0;
              idx      <= IDX_W'(1);
              resets   <= ALL_ONES << 1;
              if (CHANNELS == 1) begin
                state <= RUN;
                ready <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end else begin
            lock_cnt <= '0;
          end
        end
        RELEASE, RUN: begin
          if (!locked_sync || sw_reset_req) begin
            // Abort: lock loss takes priority and is the only one that is recorded
            state    <= HOLD;
            resets   <= ALL_ONES;
            ready    <= 1'b0;
            lock_cnt <= '0;
            stag_cnt <= '0;
            idx      <= '0;
            if (!locked_sync) begin
              lock_lost <= 1'b1;
              if (loss_count != 8'hFF) begin
                loss_count <= loss_count + 8'd1;
              end
            end
          end else if (state == RELEASE) begin
            if (stag_cnt == STAG_W'(STAGGER_CYCLES - 1)) begin
              stag_cnt <= '0;
              resets   <= resets << 1;
              idx      <= idx + 1'b1;
              if (idx == IDX_W'(CHANNELS - 1)) begin
                state <= RUN;
                ready <= 1'b1;
              end
            end else begin
              stag_cnt <= stag_cnt + 1'b1;
            end
          end else begin
            resets <= '0;
            ready  <= 1'b1;
          end
        end
        default: begin
          state  <= HOLD;
          resets <= ALL_ONES;
          ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised reset sequencer for the SoC clock domain. It synchronises an asynchronous PLL-lock indication and requires lock to be stable for a programmable window. It then releases CHANNELS active-high synchronous resets in a staggered order and re-asserts all of them on lock loss or on a software reset request. It sits between the PLL and the core/peripheral reset inputs and generalises the fixed single-channel lock-count reset generator.

## Interface
- CHANNELS, 3: number of reset outputs; ≥1
- SYNC_STAGES, 2: flops in the locked_async synchroniser; ≥2
- LOCK_CYCLES, 16: consecutive synchronised-lock cycles required before release; ≥1
- STAGGER_CYCLES, 4: cycles between successive channel releases; ≥1
- clk  input  1  system clock (PLL output)
- reset_n  input  1  asynchronous, active-low reset; sole async input besides locked_async
- locked_async  input  1  PLL lock, asynchronous to clk
- sw_reset_req  input  1  synchronous request; sampled each edge, level-sensitive
- lock_lost_clr  input  1  synchronous clear of lock_lost
- resets  output  CHANNELS  active-high resets, channel 0 released first
- ready  output  1  high when all channels are released
- lock_lost  output  1  sticky: set on any lock loss after release started
- loss_count  output  8  saturating count of lock-loss events

## Operation
- Reset (reset_n=0, async): synchroniser flops=0, state=HOLD, lock counter=0, stagger counter=0, channel index=0, resets=all 1, ready=0, lock_lost=0, loss_count=0.
- locked_sync is the last stage of the SYNC_STAGES-flop chain.
- HOLD:
  - resets all 1; ready=0.
  - On each edge with locked_sync=1 and sw_reset_req=0, the lock counter increments.
  - Any edge with locked_sync=0 or sw_reset_req=1 sets the counter to 0.
  - On the edge where the counter would reach LOCK_CYCLES: go to RELEASE, resets[0]<=0, index<=1, stagger counter<=0.
  - If CHANNELS=1, go directly to RUN with ready<=1.
- RELEASE:
  - The stagger counter increments each edge.
  - When it reaches STAGGER_CYCLES-1: resets[index]<=0, index++, counter<=0.
  - Releasing index CHANNELS-1 moves to RUN with ready<=1 on the same edge.
- RUN: resets all 0, ready=1, holds until an abort.
- Abort (RELEASE or RUN only, priority order):
  - Lock loss: locked_sync=0. Resets all <=1, ready<=0, lock_lost<=1, loss_count<=min(loss_count+1,255), state<=HOLD, lock counter<=0.
  - Software request: sw_reset_req=1 and locked_sync=1. Same as lock loss, except lock_lost and loss_count are unchanged.
- lock_lost_clr=1 clears lock_lost on the next edge. A simultaneous set wins.
- Resets never release out of order. A channel, once reasserted, is released only after a full HOLD window.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- locked_async rising to locked_sync visible: SYNC_STAGES edges.
- Release latency:
  - resets[0] falls LOCK_CYCLES edges after the first edge sampling locked_sync=1.
  - resets[k] falls k·STAGGER_CYCLES edges after resets[0].
  - ready rises with resets[CHANNELS-1].
- Abort latency:
  - 1 edge after locked_sync=0 or sw_reset_req=1 is sampled.
  - From locked_async falling: SYNC_STAGES+1 edges worst case.
- reset_n assertion is immediate (async) mid-sequence. Deassertion is taken on the next clk edge; the system integrator synchronises reset_n deassertion externally.

## Test plan
- Defaults; reset_n released at edge 0, locked_async=1 throughout -> resets[0] falls at edge 18, resets[1] at 22, resets[2] at 26; ready rises at 26; lock_lost=0.
- In HOLD, locked_async drops for 3 cycles after the counter reaches 10 -> counter restarts; resets stay 3'b111; lock_lost=0, loss_count=0; release occurs 16 edges after locked_sync returns.
- In RUN, locked_async falls -> 3 edges later resets=3'b111, ready=0, lock_lost=1, loss_count=1; after re-lock, the full 16+8 sequence repeats; lock_lost stays 1 until lock_lost_clr.
- sw_reset_req pulsed 1 cycle after resets[0] released (RELEASE) -> next edge resets=3'b111, lock_lost=0, loss_count unchanged; resets[0] re-releases 16 edges later.
- Remaining checks:
  - lock_lost_clr coincident with a lock-loss edge -> lock_lost remains 1.
  - 300 lock-loss events -> loss_count saturates at 255.
- reset_n asserted mid-RELEASE (resets=3'b100) -> same delta-cycle resets=3'b111, ready=0, counters 0; parameter sweep CHANNELS=1, STAGGER_CYCLES=1, SYNC_STAGES=3 checks latencies.
